// File: rtl/bloom_pkg.sv
// -----------------------------------------------------------------------------
// bloom_pkg
// Shared definitions for the counting Bloom filter update path.
//   - geometry constants (items per request, counter width, address width)
//   - counter maximum and the saturating increment helper
//   - state encoding of the updater FSM
// -----------------------------------------------------------------------------
package bloom_pkg;

    localparam int NUM_ITEMS  = 7;
    localparam int ITEM_WIDTH = 4;
    localparam int ADDR_WIDTH = 8;
    localparam int DEPTH      = 1 << ADDR_WIDTH;
    localparam int ITEM_CNT_W = $clog2(NUM_ITEMS);

    typedef logic [ITEM_WIDTH-1:0] count_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [ITEM_CNT_W-1:0] item_t;

    localparam count_t COUNT_MAX = '1;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    // Increment that sticks at COUNT_MAX instead of wrapping to zero.
    function automatic count_t sat_inc(input count_t x);
        return (x == COUNT_MAX) ? x : count_t'(x + 1'b1);
    endfunction

endpackage

// File: rtl/bloom_counter_ram.sv
// -----------------------------------------------------------------------------
// bloom_counter_ram
// DEPTH x ITEM_WIDTH counter storage for the counting Bloom filter.
// Ports:
//   clk      in   rising-edge clock for the write port
//   rd_addr  in   combinational read address
//   rd_data  out  counter at rd_addr (same cycle)
//   wr_en    in   write enable
//   wr_addr  in   write address
//   wr_data  in   value written at the next rising edge
// -----------------------------------------------------------------------------
module bloom_counter_ram
    import bloom_pkg::*;
(
    input  logic   clk,
    input  addr_t  rd_addr,
    output count_t rd_data,
    input  logic   wr_en,
    input  addr_t  wr_addr,
    input  count_t wr_data
);

    count_t mem [DEPTH];

    // NOTE: the array has no reset on purpose; a reset would turn it into
    // DEPTH*ITEM_WIDTH resettable flops. The owner zeroes it with a sweep.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/bloom_counter_updater.sv
// -----------------------------------------------------------------------------
// bloom_counter_updater
// Write/update side of the counting Bloom filter. Owns the counter array and
// applies each insert request (NUM_ITEMS hashed indices) by reading all
// addressed counters, tracking their minimum, then writing back saturating
// increments. Reports the post-insert count estimate sat(min+1).
//
// Build option: define CONSERVATIVE_UPDATE_EN for conservative update (only
// counters equal to the minimum are raised); otherwise every addressed
// counter is incremented.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-high reset (restarts the clear sweep)
//   inValid     in   insert request valid
//   inReady     out  high in IDLE, request accepted on inValid && inReady
//   indices     in   NUM_ITEMS packed addresses, index m at [m*ADDR_WIDTH +: ADDR_WIDTH]
//   outValid    out  one-cycle pulse when outMinimum is updated
//   outMinimum  out  post-update minimum, held until the next result
// -----------------------------------------------------------------------------
module bloom_counter_updater
    import bloom_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             inValid,
    output logic                             inReady,
    input  logic [NUM_ITEMS*ADDR_WIDTH-1:0]  indices,
    output logic                             outValid,
    output logic [ITEM_WIDTH-1:0]            outMinimum
);

    state_t state, state_next;
    addr_t  clr_ptr;
    item_t  item;
    count_t run_min;
    count_t out_min;
    addr_t  idx_q   [NUM_ITEMS];
    count_t value_q [NUM_ITEMS];

    addr_t  rd_addr, wr_addr;
    count_t rd_data, wr_data, new_val;
    logic   wr_en;

    logic handshake;
    logic item_last;

    assign inReady    = (state == IDLE);
    assign outValid   = (state == DONE);
    assign outMinimum = out_min;
    assign handshake  = inValid && inReady;
    assign item_last  = (item == item_t'(NUM_ITEMS - 1));

    // Control state. NOTE: all sequential state uses non-blocking assignments
    // so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            item    <= '0;
            run_min <= COUNT_MAX;
            out_min <= '0;
        end else begin
            state <= state_next;
            case (state)
                CLEAR: clr_ptr <= clr_ptr + 1'b1;
                IDLE: begin
                    if (handshake) begin
                        item    <= '0;
                        run_min <= COUNT_MAX;
                    end
                end
                READ: begin
                    if (rd_data < run_min) run_min <= rd_data;
                    item <= item_last ? '0 : item + 1'b1;
                end
                WRITE: begin
                    item <= item_last ? '0 : item + 1'b1;
                    if (item_last) out_min <= sat_inc(run_min);
                end
                default: ;
            endcase
        end
    end

    // Request data path; its contents are only meaningful after a handshake.
    always_ff @(posedge clk) begin
        if (handshake) begin
            for (int m = 0; m < NUM_ITEMS; m++) begin
                idx_q[m] <= indices[m*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
        if (state == READ) begin
            value_q[item] <= rd_data;
        end
    end

    // All reads finish before the first write, so duplicate indices see the
    // same old value and write the same new value (one increment total).
`ifdef CONSERVATIVE_UPDATE_EN
    assign new_val = (value_q[item] == run_min) ? sat_inc(run_min) : value_q[item];
`else
    assign new_val = sat_inc(value_q[item]);
`endif

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        rd_addr    = idx_q[item];
        wr_addr    = idx_q[item];
        wr_data    = new_val;
        wr_en      = 1'b0;
        case (state)
            CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = clr_ptr;
                wr_data = '0;
                if (clr_ptr == addr_t'(DEPTH - 1)) state_next = IDLE;
            end
            IDLE:  if (handshake) state_next = READ;
            READ:  if (item_last) state_next = WRITE;
            WRITE: begin
                wr_en = 1'b1;
                if (item_last) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = CLEAR;
        endcase
    end

    bloom_counter_ram u_ram (
        .clk     (clk),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

endmodule
